// File: rtl/fp_sgnj_pipe.sv
// rtl/fp_sgnj_pipe.sv - pipelined FP sign-injection unit (FSGNJ/FSGNJN/FSGNJX) with NaN-boxing
//
// Ports:
//   fp_sgnj_i_clk / fp_sgnj_i_rst_n   clock, asynchronous active-low reset
//   fp_sgnj_i_valid / fp_sgnj_o_ready input handshake
//   fp_sgnj_i_data1                   magnitude source operand (FLEN bits)
//   fp_sgnj_i_data2                   sign source operand (FLEN bits)
//   fp_sgnj_i_fmt                     0=F32 1=F64 2=F16 3=reserved
//   fp_sgnj_i_rm                      0=SGNJ 1=SGNJN 2=SGNJX, others reserved
//   fp_sgnj_i_tag                     tag carried with the operation
//   fp_sgnj_i_flush                   drop everything in flight
//   fp_sgnj_o_valid / fp_sgnj_i_ready output handshake
//   fp_sgnj_o_result / o_tag / o_illegal  result slot contents
//   fp_sgnj_o_count                   results accepted downstream (wraps)
module fp_sgnj_pipe #(
    parameter int FLEN   = 64,
    parameter int STAGES = 1,
    parameter int TAG_W  = 5,
    parameter int NANBOX = 1
) (
    input  logic             fp_sgnj_i_clk,
    input  logic             fp_sgnj_i_rst_n,
    input  logic             fp_sgnj_i_valid,
    output logic             fp_sgnj_o_ready,
    input  logic [FLEN-1:0]  fp_sgnj_i_data1,
    input  logic [FLEN-1:0]  fp_sgnj_i_data2,
    input  logic [1:0]       fp_sgnj_i_fmt,
    input  logic [2:0]       fp_sgnj_i_rm,
    input  logic [TAG_W-1:0] fp_sgnj_i_tag,
    input  logic             fp_sgnj_i_flush,
    output logic             fp_sgnj_o_valid,
    input  logic             fp_sgnj_i_ready,
    output logic [FLEN-1:0]  fp_sgnj_o_result,
    output logic [TAG_W-1:0] fp_sgnj_o_tag,
    output logic             fp_sgnj_o_illegal,
    output logic [31:0]      fp_sgnj_o_count
);

    localparam logic [63:0] QNAN16 = 64'h0000_0000_0000_7E00;
    localparam logic [63:0] QNAN32 = 64'h0000_0000_7FC0_0000;

    // ---------------- stage 0: combinational sign injection ----------------
    logic [6:0]      w;
    logic            legal_fmt;
    logic [FLEN-1:0] qnan;
    logic [FLEN-1:0] hi_ones;
    logic [FLEN-1:0] sign_mask;
    logic [FLEN-1:0] op1;
    logic [FLEN-1:0] op2;
    logic            s1;
    logic            s2;
    logic            sign;
    logic [FLEN-1:0] res_c;
    logic            illegal_c;

    always_comb begin
        w         = 7'd64;
        qnan      = '0;
        legal_fmt = 1'b0;
        case (fp_sgnj_i_fmt)
            2'd0: begin
                w         = 7'd32;
                qnan      = QNAN32[FLEN-1:0];
                legal_fmt = 1'b1;
            end
            2'd1: begin
                w         = 7'd64;
                legal_fmt = (FLEN == 64);
            end
            2'd2: begin
                w         = 7'd16;
                qnan      = QNAN16[FLEN-1:0];
                legal_fmt = 1'b1;
            end
            default: legal_fmt = 1'b0;
        endcase

        // Bits above the format width; shifts of FLEN or more give zero,
        // so a full-width format has no box bits and always passes the check.
        hi_ones   = {FLEN{1'b1}} << w;
        sign_mask = {{(FLEN-1){1'b0}}, 1'b1} << (w - 7'd1);

        op1 = fp_sgnj_i_data1;
        op2 = fp_sgnj_i_data2;
        if (NANBOX != 0) begin
            if ((fp_sgnj_i_data1 | ~hi_ones) != {FLEN{1'b1}}) op1 = qnan;
            if ((fp_sgnj_i_data2 | ~hi_ones) != {FLEN{1'b1}}) op2 = qnan;
        end

        s1 = |(op1 & sign_mask);
        s2 = |(op2 & sign_mask);
        case (fp_sgnj_i_rm)
            3'd0:    sign = s2;
            3'd1:    sign = ~s2;
            3'd2:    sign = s1 ^ s2;
            default: sign = 1'b0;
        endcase

        // Magnitude is everything below the sign bit of the narrow format.
        res_c = (op1 & (sign_mask - 1'b1))
              | (sign ? sign_mask : '0)
              | ((NANBOX != 0) ? hi_ones : '0);
        illegal_c = !legal_fmt || (fp_sgnj_i_rm > 3'd2);
        if (!legal_fmt) res_c = '0;
    end

    // ---------------- pipeline slots ----------------
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] ill_q;
    logic [FLEN-1:0]   res_q [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [STAGES-1:0] adv;
    logic              chain;
    logic              accept;

    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_ill;
    logic [FLEN-1:0]   src_res [STAGES];
    logic [TAG_W-1:0]  src_tag [STAGES];

    // A slot advances if it or any slot downstream of it is empty, or the
    // consumer takes the output; accumulated from the tail toward the head.
    always_comb begin
        adv   = '0;
        chain = fp_sgnj_i_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain  = chain | ~v_q[k];
            adv[k] = chain;
        end
    end

    assign fp_sgnj_o_ready = adv[0] & ~fp_sgnj_i_flush;
    assign accept          = fp_sgnj_i_valid & fp_sgnj_o_ready;

    always_comb begin
        src_v[0]   = accept;
        src_ill[0] = illegal_c;
        src_res[0] = res_c;
        src_tag[0] = fp_sgnj_i_tag;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k]   = v_q[k-1];
            src_ill[k] = ill_q[k-1];
            src_res[k] = res_q[k-1];
            src_tag[k] = tag_q[k-1];
        end
    end

    always_ff @(posedge fp_sgnj_i_clk or negedge fp_sgnj_i_rst_n) begin
        if (!fp_sgnj_i_rst_n) begin
            v_q   <= '0;
            ill_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (fp_sgnj_i_flush)  v_q[k] <= 1'b0;
                else if (adv[k])      v_q[k] <= src_v[k];
                if (adv[k]) begin
                    ill_q[k] <= src_ill[k];
                    res_q[k] <= src_res[k];
                    tag_q[k] <= src_tag[k];
                end
            end
        end
    end

    assign fp_sgnj_o_valid   = v_q[STAGES-1];
    assign fp_sgnj_o_result  = res_q[STAGES-1];
    assign fp_sgnj_o_tag     = tag_q[STAGES-1];
    assign fp_sgnj_o_illegal = ill_q[STAGES-1];

    always_ff @(posedge fp_sgnj_i_clk or negedge fp_sgnj_i_rst_n) begin
        if (!fp_sgnj_i_rst_n)                        fp_sgnj_o_count <= '0;
        else if (fp_sgnj_o_valid && fp_sgnj_i_ready) fp_sgnj_o_count <= fp_sgnj_o_count + 32'd1;
    end

endmodule

// File: tb/tb_fp_sgnj_pipe.sv
// tb/tb_fp_sgnj_pipe.sv - self-checking bench for fp_sgnj_pipe (FLEN=64, STAGES=3, NANBOX=1)
module tb_fp_sgnj_pipe;
    localparam int FLEN   = 64;
    localparam int STAGES = 3;
    localparam int TAG_W  = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [FLEN-1:0]  d1 = '0;
    logic [FLEN-1:0]  d2 = '0;
    logic [1:0]       fmt = '0;
    logic [2:0]       rm = '0;
    logic [TAG_W-1:0] tag = '0;
    logic             flush = 1'b0;
    logic             o_valid;
    logic             i_ready = 1'b1;
    logic [FLEN-1:0]  o_result;
    logic [TAG_W-1:0] o_tag;
    logic             o_illegal;
    logic [31:0]      o_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_sgnj_pipe #(.FLEN(FLEN), .STAGES(STAGES), .TAG_W(TAG_W), .NANBOX(1)) dut (
        .fp_sgnj_i_clk    (clk),
        .fp_sgnj_i_rst_n  (rst_n),
        .fp_sgnj_i_valid  (i_valid),
        .fp_sgnj_o_ready  (o_ready),
        .fp_sgnj_i_data1  (d1),
        .fp_sgnj_i_data2  (d2),
        .fp_sgnj_i_fmt    (fmt),
        .fp_sgnj_i_rm     (rm),
        .fp_sgnj_i_tag    (tag),
        .fp_sgnj_i_flush  (flush),
        .fp_sgnj_o_valid  (o_valid),
        .fp_sgnj_i_ready  (i_ready),
        .fp_sgnj_o_result (o_result),
        .fp_sgnj_o_tag    (o_tag),
        .fp_sgnj_o_illegal(o_illegal),
        .fp_sgnj_o_count  (o_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: unbox each operand to its format (or canonical qNaN, boxed),
    // then overwrite only the sign bit of operand 1. Returns {illegal, result}.
    function automatic logic [64:0] model(input logic [63:0] a_in, input logic [63:0] b_in,
                                          input logic [1:0] f, input logic [2:0] r);
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        s;
        int          w;
        case (f)
            2'd0: begin
                w = 32;
                a = (a_in[63:32] == 32'hFFFF_FFFF) ? a_in : 64'hFFFF_FFFF_7FC0_0000;
                b = (b_in[63:32] == 32'hFFFF_FFFF) ? b_in : 64'hFFFF_FFFF_7FC0_0000;
            end
            2'd1: begin
                w = 64;
                a = a_in;
                b = b_in;
            end
            2'd2: begin
                w = 16;
                a = (a_in[63:16] == 48'hFFFF_FFFF_FFFF) ? a_in : 64'hFFFF_FFFF_FFFF_7E00;
                b = (b_in[63:16] == 48'hFFFF_FFFF_FFFF) ? b_in : 64'hFFFF_FFFF_FFFF_7E00;
            end
            default: return {1'b1, 64'h0};
        endcase
        case (r)
            3'd0:    s = b[w-1];
            3'd1:    s = !b[w-1];
            3'd2:    s = a[w-1] ^ b[w-1];
            default: s = 1'b0;
        endcase
        res = a;
        res[w-1] = s;
        return {(r > 3'd2), res};
    endfunction

    // ---------------- scoreboard / compare process ----------------
    logic [69:0] sb [$];
    logic [31:0] exp_count = '0;
    logic        stall_hold = 1'b0;
    logic [63:0] held_res;
    logic [4:0]  held_tag;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_count  = '0;
            stall_hold = 1'b0;
        end else begin
            check("count", {32'h0, o_count}, {32'h0, exp_count});
            if (stall_hold) begin
                check("stall_valid", {63'h0, o_valid}, 64'h1);
                check("stall_result", o_result, held_res);
                check("stall_tag", {59'h0, o_tag}, {59'h0, held_tag});
            end
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'h1, 64'h0);
                end else begin
                    logic [69:0] e;
                    e = sb.pop_front();
                    check("result", o_result, e[63:0]);
                    check("tag", {59'h0, o_tag}, {59'h0, e[68:64]});
                    check("illegal", {63'h0, o_illegal}, {63'h0, e[69]});
                end
                exp_count = exp_count + 32'd1;
            end
            stall_hold = o_valid && !i_ready && !flush;
            held_res   = o_result;
            held_tag   = o_tag;
            if (flush) sb.delete();
            else if (i_valid && o_ready) begin
                logic [64:0] m;
                m = model(d1, d2, fmt, rm);
                sb.push_back({m[64], tag, m[63:0]});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [1:0] f,
                         input logic [2:0] r, input logic [4:0] t);
        d1 = a; d2 = b; fmt = f; rm = r; tag = t;
    endtask

    // Called just after a rising edge; returns just after the accepting edge, valid still high.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [1:0] f,
                        input logic [2:0] r, input logic [4:0] t);
        logic acc;
        acc = 1'b0;
        drive(a, b, f, r, t);
        i_valid = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk); #1;
        end
        if (!acc) check("send_timeout", 64'h1, 64'h0);
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !o_valid;
        end
        check("drain", {63'h0, done}, 64'h1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [64:0] m;
        logic [31:0] cnt_before;
        int          idx;
        int          acc_low;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid",   {63'h0, o_valid}, 64'h0);
        check("rst_ready",   {63'h0, o_ready}, 64'h1);
        check("rst_count",   {32'h0, o_count}, 64'h0);
        check("rst_result",  o_result, 64'h0);
        check("rst_tag",     {59'h0, o_tag}, 64'h0);
        check("rst_illegal", {63'h0, o_illegal}, 64'h0);

        // Pin the model against hand-computed values.
        m = model(64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_BF800000, 2'd0, 3'd0);
        check("pin_f32_rm0", m[63:0], 64'hFFFFFFFF_BF800000);
        m = model(64'h00000000_3F800000, 64'hFFFFFFFF_3F800000, 2'd0, 3'd2);
        check("pin_f32_unboxed", m[63:0], 64'hFFFFFFFF_7FC00000);
        m = model(64'h3FF0000000000000, 64'h3FF0000000000000, 2'd1, 3'd1);
        check("pin_f64_rm1", m[63:0], 64'hBFF0000000000000);
        m = model(64'hFFFFFFFFFFFF3C00, 64'hFFFFFFFFFFFFBC00, 2'd2, 3'd2);
        check("pin_f16_rm2", m[63:0], 64'hFFFFFFFFFFFFBC00);
        m = model(64'hFFFFFFFF_BF800000, 64'h0, 2'd0, 3'd5);
        check("pin_rsv_rm", m, {1'b1, 64'hFFFFFFFF_3F800000});
        m = model(64'h1234, 64'h5678, 2'd3, 3'd0);
        check("pin_rsv_fmt", m, {1'b1, 64'h0});

        // Latency: visible after edge N+STAGES-1.
        @(posedge clk); #1;
        send(64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_BF800000, 2'd0, 3'd0, 5'd9);
        i_valid = 1'b0;
        @(negedge clk);
        check("lat_e0", {63'h0, o_valid}, 64'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_e1", {63'h0, o_valid}, 64'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_e2_valid", {63'h0, o_valid}, 64'h1);
        check("lat_e2_result", o_result, 64'hFFFFFFFF_BF800000);
        check("lat_e2_illegal", {63'h0, o_illegal}, 64'h0);
        @(posedge clk); #1;
        wait_drain();

        // Remaining test-plan vectors, back to back.
        send(64'h00000000_3F800000, 64'hFFFFFFFF_3F800000, 2'd0, 3'd2, 5'd2);
        send(64'h3FF0000000000000, 64'h3FF0000000000000, 2'd1, 3'd1, 5'd3);
        send(64'hFFFFFFFFFFFF3C00, 64'hFFFFFFFFFFFFBC00, 2'd2, 3'd2, 5'd4);
        send(64'h1234, 64'h5678, 2'd3, 3'd0, 5'd5);
        send(64'hFFFFFFFF_BF800000, 64'h0, 2'd0, 3'd5, 5'd6);
        i_valid = 1'b0;
        wait_drain();

        // Throughput: mixed ops, o_ready must stay high with i_ready high.
        for (int i = 0; i < 16; i++) begin
            logic [63:0] a;
            logic [63:0] b;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 3 != 0) a[63:32] = 32'hFFFF_FFFF;
            if (i % 4 != 1) b[63:32] = 32'hFFFF_FFFF;
            if (i % 2 == 0) begin a[31:16] = 16'hFFFF; b[31:16] = 16'hFFFF; end
            drive(a, b, 2'(i % 4), 3'(i % 5), 5'(i + 10));
            i_valid = 1'b1;
            @(negedge clk);
            check("tput_ready", {63'h0, o_ready}, 64'h1);
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        wait_drain();

        // Backpressure: i_ready low for 5 cycles while streaming tags 1..6.
        cnt_before = o_count;
        i_ready = 1'b0;
        idx = 1;
        acc_low = 0;
        drive(64'hFFFFFFFF_40000000 + 64'(idx), 64'hFFFFFFFF_80000000, 2'd0, 3'd0, 5'(idx));
        i_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && idx <= 6; cyc++) begin
            if (cyc == 5) i_ready = 1'b1;
            @(negedge clk);
            if (cyc == 3 || cyc == 4) begin
                check("bp_full_ready", {63'h0, o_ready}, 64'h0);
                check("bp_head_tag", {58'h0, o_valid, o_tag}, {58'h0, 1'b1, 5'd1});
            end
            if (o_ready) begin
                if (cyc < 5) acc_low++;
                idx++;
            end
            @(posedge clk); #1;
            if (idx <= 6) drive(64'hFFFFFFFF_40000000 + 64'(idx), 64'hFFFFFFFF_80000000, 2'd0, 3'(idx % 3), 5'(idx));
            else i_valid = 1'b0;
        end
        i_valid = 1'b0;
        check("bp_accepts_stalled", 64'(acc_low), 64'd3);
        wait_drain();
        check("bp_count", {32'h0, o_count - cnt_before}, 64'd6);

        // Flush with two ops in flight and a third presented.
        send(64'hFFFFFFFF_11111111, 64'hFFFFFFFF_22222222, 2'd0, 3'd1, 5'd20);
        send(64'hFFFFFFFF_33333333, 64'hFFFFFFFF_44444444, 2'd0, 3'd1, 5'd21);
        drive(64'hFFFFFFFF_55555555, 64'hFFFFFFFF_66666666, 2'd0, 3'd1, 5'd22);
        flush = 1'b1;
        cnt_before = o_count;
        @(negedge clk);
        check("flush_ready", {63'h0, o_ready}, 64'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        i_valid = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check("flush_no_valid", {63'h0, o_valid}, 64'h0);
        end
        check("flush_count", {32'h0, o_count}, {32'h0, cnt_before});
        @(posedge clk); #1;

        // Reset mid-operation discards in-flight work immediately.
        send(64'hFFFFFFFF_3F800000, 64'h0, 2'd0, 3'd0, 5'd1);
        send(64'hFFFFFFFF_3F800000, 64'h0, 2'd0, 3'd0, 5'd2);
        send(64'hFFFFFFFF_3F800000, 64'h0, 2'd0, 3'd0, 5'd3);
        i_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", {63'h0, o_valid}, 64'h0);
        check("midrst_count", {32'h0, o_count}, 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready", {63'h0, o_ready}, 64'h1);
        check("midrst_novalid", {63'h0, o_valid}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_sgnj_pipe.md
# fp_sgnj_pipe

Pipelined, parametrised sign-injection unit (FSGNJ / FSGNJN / FSGNJX) for the FPU execute stage, supporting F16, F32 and F64 operands held in FLEN-bit FP registers. It adds NaN-box checking and boxing, a valid/ready handshake with a configurable pipeline depth, an operation tag, an illegal-encoding flag, a flush, and a completed-operation counter. It sits between the FPU issue logic and the FP register-file writeback arbiter.

## Interface
- FLEN, 64: register width; legal values 32 or 64.
- STAGES, 1: pipeline register stages, 1..3.
- TAG_W, 5: width of the pass-through tag (destination register index).
- NANBOX, 1: 1 = check NaN-boxing on inputs and box outputs; 0 = narrow results are zero-extended.

Ports:
- fp_sgnj_i_clk  in  1  clock; all state updates on the rising edge.
- fp_sgnj_i_rst_n  in  1  reset, asynchronous, active-low.
- fp_sgnj_i_valid  in  1  input operation valid.
- fp_sgnj_o_ready  out  1  unit can accept an input this cycle.
- fp_sgnj_i_data1  in  FLEN  magnitude source operand.
- fp_sgnj_i_data2  in  FLEN  sign source operand.
- fp_sgnj_i_fmt  in  2  0=F32, 1=F64, 2=F16, 3=reserved.
- fp_sgnj_i_rm  in  3  0=FSGNJ, 1=FSGNJN, 2=FSGNJX, 3..7 reserved.
- fp_sgnj_i_tag  in  TAG_W  tag carried alongside the operation.
- fp_sgnj_i_flush  in  1  synchronous flush of all in-flight operations.
- fp_sgnj_o_valid  out  1  result valid.
- fp_sgnj_i_ready  in  1  downstream accepts the result.
- fp_sgnj_o_result  out  FLEN  result.
- fp_sgnj_o_tag  out  TAG_W  tag of the result.
- fp_sgnj_o_illegal  out  1  reserved fmt or rm encoding.
- fp_sgnj_o_count  out  32  number of results accepted downstream (wraps).

## Operation
- Width W per fmt: F16=16, F32=32, F64=64. The sign bit is bit W-1.
- NaN-box check (NANBOX=1, W<FLEN): if an operand's bits [FLEN-1:W] are not all ones, that operand is replaced by the canonical qNaN (F16 0x7E00, F32 0x7FC00000) before the operation.
- Result: bits [W-2:0] = data1[W-2:0]. Sign = data2[W-1] (rm 0), ~data2[W-1] (rm 1), or data1[W-1]^data2[W-1] (rm 2).
- Upper bits [FLEN-1:W] are all ones if NANBOX=1, otherwise zero.
- rm 3..7 with a legal fmt: sign = 0, magnitude as above, illegal = 1.
- fmt 3, or fmt 1 with FLEN=32: result = 0, illegal = 1.
- Pipeline: the result is computed combinationally at stage 0 and registered through STAGES slots, each holding valid, result, tag and illegal.
- Per-slot ready: slot k advances when it is empty or slot k+1 advances. The last slot advances on fp_sgnj_i_ready.
- fp_sgnj_o_ready = (stage-0 slot empty or it advances) and !fp_sgnj_i_flush.
- Flush: all valid bits clear on the next edge. An input presented in the flush cycle is not accepted. The counter is unaffected.
- Counter: increments by 1 on each cycle where fp_sgnj_o_valid && fp_sgnj_i_ready, including in the same cycle as a flush. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (async assert, sync deassert by the clock): all valid bits, result, tag, illegal and count = 0. fp_sgnj_o_ready = 1 after reset.
- Latency: an input accepted at edge N appears on fp_sgnj_o_valid after edge N+STAGES-1, i.e. for STAGES=1 it is visible in the cycle after acceptance.
- Throughput: 1 operation per cycle with fp_sgnj_i_ready held high. No bubbles are inserted.
- Stall: while o_valid && !i_ready, the outputs hold stable. Upstream slots fill, and o_ready drops only when all STAGES slots are full.
- Simultaneous output drain and input accept with a full pipeline is supported (o_ready stays 1).
- Reset asserted mid-operation discards all in-flight operations immediately.

## Test plan
- F32 boxed, FLEN=64, rm0: d1=0xFFFFFFFF_3F800000, d2=0xFFFFFFFF_BF800000 -> result 0xFFFFFFFF_BF800000, illegal 0, after STAGES cycles.
- F32 unboxed d1, rm2: d1=0x00000000_3F800000, d2=0xFFFFFFFF_3F800000 -> result 0xFFFFFFFF_7FC00000.
- F64 rm1: d1=0x3FF0000000000000, d2=0x3FF0000000000000 -> 0xBFF0000000000000. F16 rm2: d1=0xFFFFFFFFFFFF3C00, d2=0xFFFFFFFFFFFFBC00 -> 0xFFFFFFFFFFFFBC00.
- Reserved encodings: fmt=3 -> result 0, illegal 1. fmt=0 with rm=5 and boxed d1=0xFFFFFFFF_BF800000 -> 0xFFFFFFFF_3F800000, illegal 1.
- Backpressure, STAGES=3: stream 6 ops with tags 1..6, hold i_ready low for 5 cycles -> o_ready falls after 3 accepts, the output holds tag 1 stable, then results arrive in order 1..6 with no loss or duplication; count = 6.
- Flush with 2 ops in flight plus a presented input -> no o_valid afterwards, that input is not accepted (o_ready=0 during flush), count unchanged.
